// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the downstream decoder.
package fetch_stage_pkg;

   // Fetch sequencer states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_BOOT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Major opcodes, shared with the decoder/controller
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;

   // Force an address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush turns the slot into a bubble and wins over
// hold; hold keeps the current contents; otherwise a valid word is captured.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_b_i,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pcplus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pcplus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q;
   logic [31:0] pcplus4_q;
   logic        valid_q;

   // Register update: reset/flush -> bubble, hold -> keep, else capture
   always_ff @(posedge clk_i) begin
      if (!rst_b_i || flush_i) begin
         instr_q   <= NOP_WORD;
         pcplus4_q <= 32'h0000_0000;
         valid_q   <= 1'b0;
      end else if (!hold_i) begin
         instr_q   <= instr_i;
         pcplus4_q <= pcplus4_i;
         valid_q   <= 1'b1;
      end
   end

   assign instr_o   = instr_q;
   assign pcplus4_o = pcplus4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch sequencer and IF/ID register.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_BOOT   | one memory-settle cycle after reset, IF/ID forced to bubble
//  ST_RUN    | fetching; priority redirect > halt > stall > fetch
//  ST_HALTED | fetch stopped, IF/ID bubble; redirect still updates PC
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic        Halt,
   input  logic        Resume,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemData,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  fetch_cnt_q;
   logic [31:0]  pc_plus4;
   logic         fetch_en;
   logic         ifid_flush;
   logic         ifid_hold;

   assign pc_plus4 = pc_q + 32'd4;

   // Decide this cycle's IF/ID action from state and hazard/redirect inputs
   always_comb begin
      fetch_en   = 1'b0;
      ifid_flush = 1'b1;
      ifid_hold  = 1'b1;
      if (state_q == ST_RUN) begin
         if (PCSrc || Halt) begin
            ifid_flush = 1'b1;
         end else if (Stall) begin
            ifid_flush = 1'b0;
         end else begin
            ifid_flush = 1'b0;
            ifid_hold  = 1'b0;
            fetch_en   = 1'b1;
         end
      end
   end

   // Sequencer, PC and fetch counter
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC_AL;
         fetch_cnt_q <= 32'h0000_0000;
      end else begin
         unique case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (PCSrc) begin
                  pc_q <= word_align(BranchTarget);
               end else if (Halt) begin
                  state_q <= ST_HALTED;
               end else if (fetch_en) begin
                  pc_q <= pc_plus4;
                  if (fetch_cnt_q != 32'hFFFF_FFFF) begin
                     fetch_cnt_q <= fetch_cnt_q + 32'd1;
                  end
               end
            end
            ST_HALTED: begin
               if (PCSrc) begin
                  pc_q <= word_align(BranchTarget);
               end
               if (Resume) begin
                  state_q <= ST_RUN;
               end
            end
            default: begin
               state_q <= ST_BOOT;
            end
         endcase
      end
   end

   if_id_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk_i     (Clk),
      .rst_b_i   (Rst),
      .hold_i    (ifid_hold),
      .flush_i   (ifid_flush),
      .instr_i   (IMemData),
      .pcplus4_i (pc_plus4),
      .instr_o   (IF_ID_Instruction),
      .pcplus4_o (IF_ID_PCPlus4),
      .valid_o   (IF_ID_Valid)
   );

   assign IMemAddr   = pc_q;
   assign PC         = pc_q;
   assign FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (default reset PC and one near the top
// of the address space) checked every cycle against a rule-level model, plus
// directed literal checks of the key scenarios.
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic        Halt;
   logic        Resume;

   logic [31:0] addr0, pc0, ins0, p40, cnt0, imem0;
   logic [31:0] addr1, pc1, ins1, p41, cnt1, imem1;
   logic        v0, v1;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   // Instruction memory image: word tagged with its own address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2000_0000 | a;
   endfunction

   assign imem0 = mem_word(addr0);
   assign imem1 = mem_word(addr1);

   fetch_stage dut0 (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc),
      .BranchTarget(BranchTarget), .Halt(Halt), .Resume(Resume),
      .IMemAddr(addr0), .IMemData(imem0), .PC(pc0),
      .IF_ID_Instruction(ins0), .IF_ID_PCPlus4(p40),
      .IF_ID_Valid(v0), .FetchCount(cnt0)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc),
      .BranchTarget(BranchTarget), .Halt(Halt), .Resume(Resume),
      .IMemAddr(addr1), .IMemData(imem1), .PC(pc1),
      .IF_ID_Instruction(ins1), .IF_ID_PCPlus4(p41),
      .IF_ID_Valid(v1), .FetchCount(cnt1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] rp    [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
   logic [31:0] m_pc  [2];
   logic [31:0] m_ins [2];
   logic [31:0] m_p4  [2];
   logic [31:0] m_cnt [2];
   logic        m_v   [2];
   bit          m_booting [2];
   bit          m_halted  [2];
   bit          model_ok = 0;

   task automatic bubble(input int k);
      m_ins[k] = 32'h0000_0000;
      m_p4[k]  = 32'h0000_0000;
      m_v[k]   = 1'b0;
   endtask

   always @(posedge Clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!Rst) begin
            m_pc[k] = rp[k];
            m_cnt[k] = 0;
            bubble(k);
            m_booting[k] = 1;
            m_halted[k] = 0;
         end else if (m_booting[k]) begin
            bubble(k);
            m_booting[k] = 0;
         end else if (m_halted[k]) begin
            if (PCSrc) m_pc[k] = BranchTarget & 32'hFFFF_FFFC;
            if (Resume) m_halted[k] = 0;
            bubble(k);
         end else if (PCSrc) begin
            m_pc[k] = BranchTarget & 32'hFFFF_FFFC;
            bubble(k);
         end else if (Halt) begin
            bubble(k);
            m_halted[k] = 1;
         end else if (!Stall) begin
            m_ins[k] = mem_word(m_pc[k]);
            m_p4[k]  = m_pc[k] + 4;
            m_v[k]   = 1'b1;
            if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
            m_pc[k]  = m_pc[k] + 4;
         end
      end
      if (!Rst) model_ok = 1;
   end

   // Every-cycle comparison against the model
   always @(negedge Clk) begin
      if (model_ok) begin
         chk("pc0",    pc0,   m_pc[0]);
         chk("addr0",  addr0, m_pc[0]);
         chk("ins0",   ins0,  m_ins[0]);
         chk("p4_0",   p40,   m_p4[0]);
         chk("v0",     {31'd0, v0}, {31'd0, m_v[0]});
         chk("cnt0",   cnt0,  m_cnt[0]);
         chk("pc1",    pc1,   m_pc[1]);
         chk("addr1",  addr1, m_pc[1]);
         chk("ins1",   ins1,  m_ins[1]);
         chk("p4_1",   p41,   m_p4[1]);
         chk("v1",     {31'd0, v1}, {31'd0, m_v[1]});
         chk("cnt1",   cnt1,  m_cnt[1]);
      end
   end

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      Rst = 1'b0; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
      Halt = 1'b0; Resume = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_pc",    pc0,  32'h0);
      chk("rst_valid", {31'd0, v0}, 32'h0);
      chk("rst_ins",   ins0, 32'h0);
      chk("rst_cnt",   cnt0, 32'h0);
      chk("rst_pc_hi", pc1,  32'hFFFF_FFF8);

      // boot cycle then three fetches
      Rst = 1'b1;
      step();
      chk("boot_valid", {31'd0, v0}, 32'h0);
      chk("boot_pc",    pc0, 32'h0);
      chk("boot_pc_hi", pc1, 32'hFFFF_FFF8);
      step();
      chk("f0_ins", ins0, 32'h2000_0000);
      chk("f0_p4",  p40,  32'h4);
      chk("hi_pc_a", pc1, 32'hFFFF_FFFC);
      chk("hi_p4_a", p41, 32'hFFFF_FFFC);
      step();
      chk("f1_ins", ins0, 32'h2000_0004);
      chk("f1_p4",  p40,  32'h8);
      chk("hi_pc_wrap", pc1, 32'h0);
      chk("hi_p4_wrap", p41, 32'h0);
      step();
      chk("f2_ins", ins0, 32'h2000_0008);
      chk("f2_p4",  p40,  32'hC);
      chk("f2_cnt", cnt0, 32'd3);
      chk("hi_pc_c", pc1, 32'h4);

      // stall three cycles at PC 0x10
      step();
      chk("pre_stall_pc", pc0, 32'h10);
      Stall = 1'b1;
      repeat (3) step();
      chk("stall_pc",  pc0,  32'h10);
      chk("stall_ins", ins0, 32'h2000_000C);
      chk("stall_cnt", cnt0, 32'd4);
      Stall = 1'b0;
      step();
      chk("unstall_pc",  pc0,  32'h14);
      chk("unstall_ins", ins0, 32'h2000_0010);

      // redirect with concurrent stall at PC 0x20
      repeat (3) step();
      chk("pre_br_pc", pc0, 32'h20);
      PCSrc = 1'b1; Stall = 1'b1; BranchTarget = 32'h0000_0103;
      step();
      chk("br_pc",    pc0, 32'h100);
      chk("br_valid", {31'd0, v0}, 32'h0);
      chk("br_ins",   ins0, 32'h0);
      chk("br_cnt",   cnt0, 32'd8);
      PCSrc = 1'b0; Stall = 1'b0;
      step();
      chk("br_fetch_ins", ins0, 32'h2000_0100);
      chk("br_fetch_p4",  p40,  32'h104);

      // halt at PC 0x40, resume after 5 cycles
      PCSrc = 1'b1; BranchTarget = 32'h40;
      step();
      PCSrc = 1'b0; Halt = 1'b1;
      step();
      Halt = 1'b0;
      repeat (5) step();
      chk("halt_pc",    pc0, 32'h40);
      chk("halt_valid", {31'd0, v0}, 32'h0);
      Resume = 1'b1;
      step();
      Resume = 1'b0;
      chk("resume_pc", pc0, 32'h40);
      step();
      chk("resume_ins",   ins0, 32'h2000_0040);
      chk("resume_valid", {31'd0, v0}, 32'h1);
      chk("resume_cnt",   cnt0, 32'd10);

      // redirect while halted stays halted
      Halt = 1'b1;
      step();
      Halt = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h0000_0202;
      step();
      PCSrc = 1'b0;
      step();
      chk("halt_br_pc", pc0, 32'h200);
      chk("halt_br_v",  {31'd0, v0}, 32'h0);

      // reset during halt with concurrent redirect
      Rst = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h300;
      step();
      chk("hrst_pc",  pc0,  32'h0);
      chk("hrst_cnt", cnt0, 32'h0);
      chk("hrst_p4",  p40,  32'h0);
      Rst = 1'b1; PCSrc = 1'b0;
      step();
      chk("hrst_boot_v", {31'd0, v0}, 32'h0);
      step();
      chk("hrst_f_ins", ins0, 32'h2000_0000);
      chk("hrst_f_cnt", cnt0, 32'd1);

      // halt beats stall
      Halt = 1'b1; Stall = 1'b1;
      step();
      chk("hs_pc", pc0, 32'h4);
      chk("hs_v",  {31'd0, v0}, 32'h0);
      Halt = 1'b0; Stall = 1'b0; Resume = 1'b1;
      step();
      Resume = 1'b0;
      step();
      chk("hs_ins", ins0, 32'h2000_0004);
      chk("hs_cnt", cnt0, 32'd2);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on bubble/flush.
REQ-003 Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 Stall  input  1  hazard hold request from decode; hold PC and IF/ID.
REQ-006 PCSrc  input  1  taken branch/redirect from later stage.
REQ-007 BranchTarget  input  32  redirect address, valid when PCSrc=1.
REQ-008 Halt  input  1  stop fetching after the current cycle.
REQ-009 Resume  input  1  restart fetching from held PC while halted.
REQ-010 IMemAddr  output  32  instruction memory address, combinationally equal to PC.
REQ-011 IMemData  input  32  instruction memory read data, same-cycle (asynchronous read).
REQ-012 PC  output  32  current fetch PC register.
REQ-013 IF_ID_Instruction  output  32  registered instruction word for the decoder/controller.
REQ-014 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-015 IF_ID_Valid  output  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.
REQ-016 FetchCount  output  32  count of instructions written to IF/ID with Valid=1.

Function
REQ-017 FSM states: BOOT, RUN, HALTED; BOOT entered on reset, exits to RUN unconditionally after one cycle.
REQ-018 BOOT: PC holds RESET_PC, IF/ID loads NOP_WORD with Valid=0 (memory settle cycle).
REQ-019 RUN priority per edge: PCSrc > Halt > Stall > normal fetch.
REQ-020 RUN normal: PC <= PC+4; IF/ID <= {IMemData, PC+4, Valid=1}; latency fetch-to-IF/ID = 1 cycle.
REQ-021 RUN PCSrc=1: PC <= {BranchTarget[31:2], 2'b00}; IF/ID <= NOP_WORD, Valid=0 (flush wrong-path instruction), regardless of Stall/Halt.
REQ-022 RUN Stall=1, PCSrc=0, Halt=0: PC, IF/ID, FetchCount unchanged.
REQ-023 RUN Halt=1, PCSrc=0: PC unchanged; IF/ID <= NOP_WORD, Valid=0; go HALTED.
REQ-024 HALTED: PC and IF/ID held at bubble; Resume=1 -> RUN next cycle, fetch resumes at held PC; PCSrc=1 in HALTED loads BranchTarget into PC and stays HALTED unless Resume also 1.
REQ-025 PC arithmetic modulo 2^32: PC 32'hFFFFFFFC + 4 wraps to 32'h00000000, IF_ID_PCPlus4 likewise.
REQ-026 PC[1:0] always 2'b00; BranchTarget[1:0] ignored.
REQ-027 FetchCount increments by 1 exactly on edges where IF/ID is written with Valid=1; saturates at 32'hFFFFFFFF.
REQ-028 IMemAddr combinational from PC only; no combinational path from Stall/PCSrc to IMemAddr.

Reset
REQ-029 On rising Clk with Rst=0: PC=RESET_PC, IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0, state=BOOT.
REQ-030 Reset overrides all inputs, including mid-stall, mid-halt and concurrent PCSrc.
REQ-031 Outputs defined from first Clk edge with Rst=0; no asynchronous behaviour.

Structure
REQ-032 Shared package holds FSM state encoding (2-bit), NOP_WORD default, RESET_PC default, and opcode constants also used by the decoder.
REQ-033 One sub-module: if_id_reg (IF/ID pipeline register with hold and flush-to-bubble controls); PC register and FSM stay in fetch_stage.

Verification
REQ-034 Reset then 4 free cycles, IMemData = 0x20000000|addr -> IF/ID Valid=0 at BOOT, then instructions for PC 0x0,0x4,0x8 with PCPlus4 0x4,0x8,0xC; FetchCount=3.
REQ-035 Stall held 3 cycles at PC 0x10 -> PC, IF/ID, FetchCount frozen; release -> PC 0x14 next edge.
REQ-036 PCSrc=1, Stall=1, BranchTarget=0x00000103 at PC 0x20 -> PC=0x100, IF_ID_Valid=0, instruction=NOP_WORD; next edge fetches 0x100.
REQ-037 RESET_PC=0xFFFFFFF8 -> PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; PCPlus4 0xFFFFFFFC, 0x00000000.
REQ-038 Halt at PC 0x40 -> HALTED, Valid=0, PC=0x40; Resume after 5 cycles -> RUN, next instruction from 0x40.
REQ-039 Rst=0 asserted during HALTED with PCSrc=1 -> all outputs at reset values, state BOOT next cycle.
